// File: rtl/tetron_pkg.sv
// tetron_pkg: shared types and constant tables for the tetromino shaper.
// Base table holds rotation-0 (v,h) offsets, blk1 first.
package tetron_pkg;

  typedef enum logic [2:0] {
    P_I, P_O, P_T, P_S, P_Z, P_J, P_LA, P_EMPTY
  } piece_t;

  typedef enum logic [2:0] {
    S_IDLE, S_PROPOSE, S_WAIT, S_RESOLVE, S_DONE
  } state_t;

  localparam int BASE_V [7][4] = '{
    '{0, 0,  0,  0},
    '{0, 0,  1,  1},
    '{0, 0,  0, -1},
    '{0, 0, -1, -1},
    '{0, 0, -1, -1},
    '{0, 0,  0, -1},
    '{0, 0,  0, -1}
  };

  localparam int BASE_H [7][4] = '{
    '{0,  1, -1,  2},
    '{0,  1,  0,  1},
    '{0,  1, -1,  0},
    '{0, -1,  0,  1},
    '{0,  1,  0, -1},
    '{0,  1, -1,  1},
    '{0,  1, -1, -1}
  };

  localparam int KICK_SEQ [4] = '{1, -1, 2, -2};

  // attempt 0 is the unshifted try
  function automatic int kick_of(input logic [2:0] idx);
    case (idx)
      3'd1:    kick_of = KICK_SEQ[0];
      3'd2:    kick_of = KICK_SEQ[1];
      3'd3:    kick_of = KICK_SEQ[2];
      3'd4:    kick_of = KICK_SEQ[3];
      default: kick_of = 0;
    endcase
  endfunction

endpackage

// File: rtl/tetron_shaper_if.sv
// tetron_shaper_if: controller, checker and renderer signals of the shaper.
// master drives requests and checker responses; slave is the shaper.
interface tetron_shaper_if #(
  parameter int OFFSET_W = 5
);
  import tetron_pkg::*;

  logic                  piece_load;
  piece_t                piece_type;
  logic                  rot_req;
  logic                  rot_dir;
  logic                  rot_ready;
  logic                  chk_valid;
  logic [4*OFFSET_W-1:0] chk_voffset;
  logic [4*OFFSET_W-1:0] chk_hoffset;
  logic [OFFSET_W-1:0]   chk_kick;
  logic                  chk_done;
  logic                  chk_ok;
  logic [4*OFFSET_W-1:0] blk_voffset;
  logic [4*OFFSET_W-1:0] blk_hoffset;
  logic [1:0]            rotation;
  logic                  rot_done;
  logic                  rot_ok;
  logic [OFFSET_W-1:0]   kick_h;

  modport master (
    output piece_load, piece_type, rot_req, rot_dir,
    output chk_done, chk_ok,
    input  rot_ready, chk_valid, chk_voffset, chk_hoffset,
    input  chk_kick, blk_voffset, blk_hoffset, rotation,
    input  rot_done, rot_ok, kick_h
  );

  modport slave (
    input  piece_load, piece_type, rot_req, rot_dir,
    input  chk_done, chk_ok,
    output rot_ready, chk_valid, chk_voffset, chk_hoffset,
    output chk_kick, blk_voffset, blk_hoffset, rotation,
    output rot_done, rot_ok, kick_h
  );

endinterface

// File: rtl/tetron_rotate.sv
// tetron_rotate: quarter-turn of one (v,h) offset pair.
// cw maps (v,h) to (h,-v); ccw maps (v,h) to (-h,v).
module tetron_rotate #(
  parameter int OFFSET_W = 5
) (
  input  logic [OFFSET_W-1:0] v,
  input  logic [OFFSET_W-1:0] h,
  input  logic                ccw,
  output logic [OFFSET_W-1:0] rv,
  output logic [OFFSET_W-1:0] rh
);

  always_comb begin
    if (ccw) begin
      rv = -h;
      rh = v;
    end else begin
      rv = h;
      rh = -v;
    end
  end

endmodule

// File: rtl/tetron_shaper.sv
// tetron_shaper: tetromino offset generator with checked rotation
// and horizontal wall-kick retries.
module tetron_shaper
  import tetron_pkg::*;
#(
  parameter int OFFSET_W = 5,
  parameter int N_KICKS  = 2
) (
  input logic            clk,
  input logic            rst_n,
  tetron_shaper_if.slave bus
);

  localparam int VW = 4 * OFFSET_W;

  state_t              state, nstate;
  piece_t              ptype;
  logic                dir, ok;
  logic [2:0]          kidx;
  logic [1:0]          rot;
  logic [VW-1:0]       blk_v, blk_h;
  logic [VW-1:0]       cand_v, cand_h;
  logic [VW-1:0]       rot_v, rot_h;
  logic [VW-1:0]       load_v, load_h;
  logic [OFFSET_W-1:0] kick, kick_h;
  logic                last_try, fixed;

  assign last_try = kidx >= 3'(N_KICKS);
  assign fixed    = (ptype == P_O) || (ptype == P_EMPTY);

  for (genvar b = 0; b < 4; b++) begin : g_rot
    tetron_rotate #(.OFFSET_W(OFFSET_W)) u_rot (
      .v   (blk_v[b*OFFSET_W +: OFFSET_W]),
      .h   (blk_h[b*OFFSET_W +: OFFSET_W]),
      .ccw (dir),
      .rv  (rot_v[b*OFFSET_W +: OFFSET_W]),
      .rh  (rot_h[b*OFFSET_W +: OFFSET_W])
    );
  end

  always_comb begin
    load_v = '0;
    load_h = '0;
    if (bus.piece_type != P_EMPTY) begin
      for (int b = 0; b < 4; b++) begin
        load_v[b*OFFSET_W +: OFFSET_W] =
          OFFSET_W'(BASE_V[bus.piece_type][b]);
        load_h[b*OFFSET_W +: OFFSET_W] =
          OFFSET_W'(BASE_H[bus.piece_type][b]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      S_IDLE:
        if (bus.rot_req)
          nstate = fixed ? S_DONE : S_PROPOSE;
      S_PROPOSE: nstate = S_WAIT;
      S_WAIT:
        if (bus.chk_done)
          nstate = (bus.chk_ok || last_try) ? S_RESOLVE : S_PROPOSE;
      S_RESOLVE: nstate = S_DONE;
      S_DONE:    nstate = S_IDLE;
      default:   nstate = S_IDLE;
    endcase
    if (bus.piece_load) nstate = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptype  <= P_EMPTY;
      dir    <= 1'b0;
      ok     <= 1'b0;
      kidx   <= '0;
      rot    <= '0;
      blk_v  <= '0;
      blk_h  <= '0;
      cand_v <= '0;
      cand_h <= '0;
      kick   <= '0;
      kick_h <= '0;
    end else if (bus.piece_load) begin
      ptype <= bus.piece_type;
      rot   <= '0;
      blk_v <= load_v;
      blk_h <= load_h;
    end else begin
      unique case (state)
        S_IDLE:
          if (bus.rot_req) begin
            dir  <= bus.rot_dir;
            kidx <= '0;
            ok   <= (ptype == P_O);
            if (fixed) kick_h <= '0;
            // O keeps its shape; only the index turns
            if (ptype == P_O)
              rot <= bus.rot_dir ? rot - 2'd1 : rot + 2'd1;
          end
        S_PROPOSE: begin
          cand_v <= rot_v;
          cand_h <= rot_h;
          kick   <= OFFSET_W'(kick_of(kidx));
        end
        S_WAIT:
          if (bus.chk_done) begin
            ok <= bus.chk_ok;
            if (!bus.chk_ok && !last_try) kidx <= kidx + 3'd1;
          end
        S_RESOLVE:
          if (ok) begin
            blk_v  <= cand_v;
            blk_h  <= cand_h;
            rot    <= dir ? rot - 2'd1 : rot + 2'd1;
            kick_h <= kick;
          end else begin
            kick_h <= '0;
          end
        default: ;
      endcase
    end
  end

  assign bus.rot_ready   = (state == S_IDLE);
  assign bus.chk_valid   = (state == S_WAIT);
  assign bus.rot_done    = (state == S_DONE);
  assign bus.rot_ok      = (state == S_DONE) && ok;
  assign bus.chk_voffset = cand_v;
  assign bus.chk_hoffset = cand_h;
  assign bus.chk_kick    = kick;
  assign bus.blk_voffset = blk_v;
  assign bus.blk_hoffset = blk_h;
  assign bus.rotation    = rot;
  assign bus.kick_h      = kick_h;

endmodule
